// File: rtl/shrg_ctrl.sv
// shrg_ctrl: sequencer for one shrg shift register.
// Arbitrates between a serial bit stream, deserialized N bits at a time, and
// a host parallel-load request. It drives the shrg shift/wri/set/data controls
// and offers each committed word to a consumer over valid/ready.
// Optional feature: define SHRG_CTRL_TIMEOUT_EN to abort a partial serial word
// after TO_CYC idle cycles in SHIFT. The abort pulses err and issues no set.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no word in flight; accepts a serial bit or a host load
// SHIFT  | collecting serial bits; cnt = bits received so far
// LOAD   | wri=1 for one cycle, so the shrg buffer takes the parallel word
// COMMIT | set=1 for one cycle, so shrg.o takes the buffer
// HOLD   | word_valid=1 until the consumer takes the word; serial stalled
module shrg_ctrl #(
    parameter int N      = 8,
    parameter int TO_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic ser_valid,
    input  logic ser_bit,
    output logic ser_ready,
    input  logic ld_req,
    output logic ld_ack,
    output logic shift,
    output logic wri,
    output logic set,
    output logic data,
    output logic word_valid,
    input  logic word_ready,
    output logic busy,
    output logic err
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        LOAD   = 3'd2,
        COMMIT = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // A pending load holds off serial only at a word boundary; mid-word the
    // serial stream keeps priority.
    assign ser_ready = ((state == IDLE) && (!ld_req || (cnt != '0))) ||
                       (state == SHIFT);
    assign shift     = ser_valid & ser_ready;
    assign data      = ser_bit;
    assign busy      = (state != IDLE) || (cnt != '0);

`ifdef SHRG_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(TO_CYC);

    // Idle-cycle down-counter, reloaded on every accepted bit.
    logic [TW-1:0] to_cnt;
`else
    assign err = 1'b0;
`endif

    // Sequencer state, bit counter and registered control outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            ld_ack     <= 1'b0;
            wri        <= 1'b0;
            set        <= 1'b0;
            word_valid <= 1'b0;
`ifdef SHRG_CTRL_TIMEOUT_EN
            err        <= 1'b0;
            to_cnt     <= '0;
`endif
        end else begin
            ld_ack <= 1'b0;
            wri    <= 1'b0;
            set    <= 1'b0;
`ifdef SHRG_CTRL_TIMEOUT_EN
            err    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (ld_req && (cnt == '0)) begin
                        state  <= LOAD;
                        ld_ack <= 1'b1;
                        wri    <= 1'b1;
                    end else if (shift) begin
                        state  <= SHIFT;
                        cnt    <= CW'(1);
`ifdef SHRG_CTRL_TIMEOUT_EN
                        to_cnt <= TO_LOAD;
`endif
                    end
                end
                SHIFT: begin
                    if (shift) begin
                        if (cnt == CNT_LAST) begin
                            state <= COMMIT;
                            cnt   <= '0;
                            set   <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
`ifdef SHRG_CTRL_TIMEOUT_EN
                        to_cnt <= TO_LOAD;
                    end else if (to_cnt <= TW'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                        err   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt - TW'(1);
`endif
                    end
                end
                LOAD: begin
                    state <= COMMIT;
                    set   <= 1'b1;
                end
                COMMIT: begin
                    state      <= HOLD;
                    word_valid <= 1'b1;
                end
                HOLD: begin
                    if (word_ready) begin
                        state      <= IDLE;
                        word_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
